gpio_arb_ctrl: RTL and testbench
================================

GPIO_ARB_CTRL -- requirements
Module: gpio_arb_ctrl

Interface
REQ-001 SHALL have parameter SW_W, default 18, the number of raw switch inputs.
REQ-002 SHALL have parameter NDIG, default 8, the number of 4-bit hex digits scanned from gpio_out.
REQ-003 SHALL have port clk, input, 1, the single clock; all state is rising-edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port sw_in, input, SW_W, raw switches, asynchronous to clk.
REQ-006 SHALL have port gpio_in, output, 32, {(32-SW_W) zeros, synchronized switches}.
REQ-007 SHALL have port sw_chg, output, 1, a one-cycle pulse when the synchronized switches change.
REQ-008 SHALL have ports cpu_req, input, 1, and cpu_wdata, input, 32, for the CPU write request and data.
REQ-009 SHALL have port cpu_gnt, output, 1, the CPU write grant.
REQ-010 SHALL have ports dbg_req, input, 1, and dbg_wdata, input, 32, for the debug/host write request and data.
REQ-011 SHALL have port dbg_gnt, output, 1, the debug write grant.
REQ-012 SHALL have port gpio_out, output, 32, the display register.
REQ-013 SHALL have ports disp_valid, output, 1, disp_sel, output, 3, and disp_digit, output, 4, the digit scan to the hexdriver.

Function
REQ-014 SHALL synchronize sw_in through two flops, so gpio_in reflects sw_in 2 cycles later.
REQ-015 SHALL pulse sw_chg for exactly 1 cycle when the 2nd-stage value differs from its previous value; it SHALL NOT pulse on the first cycle after reset.
REQ-016 SHALL implement FSM states IDLE and SCAN.
REQ-017 In IDLE with any request high, SHALL at the next edge:
- pulse the winner's gnt for 1 cycle;
- load gpio_out with the winner's wdata;
- set disp_sel=0 and enter SCAN.
REQ-018 SHALL assert at most one gnt in any cycle; gnt SHALL never assert in the cycle after a SCAN cycle unless IDLE sampled a request.
REQ-019 SHALL arbitrate simultaneous requests round-robin: the requester not granted last wins; after reset the CPU wins first.
REQ-020 A lone requester SHALL win regardless of the round-robin pointer; the pointer SHALL update only on a grant.
REQ-021 In SCAN, SHALL hold disp_valid=1 for exactly NDIG cycles, with disp_sel counting 0..NDIG-1 and disp_digit=gpio_out[4*disp_sel+3:4*disp_sel].
- After disp_sel=NDIG-1, SHALL return to IDLE with disp_valid=0.
REQ-022 SHALL ignore requests during SCAN.
- Requesters hold req until gnt.
- Earliest back-to-back grant spacing is NDIG+1 cycles.
REQ-023 SHALL still load gpio_out and perform a full scan on a write of data equal to the current gpio_out.
REQ-024 SHALL keep gpio_out stable except on the grant edge.

Reset
REQ-025 SHALL, while rst=0, immediately force all of the following, including mid-SCAN:
- gpio_out=0, gpio_in=0, sw_chg=0;
- cpu_gnt=0, dbg_gnt=0;
- disp_valid=0, disp_sel=0, disp_digit=0;
- sync flops to 0, FSM to IDLE, round-robin pointer to CPU-first.
REQ-026 SHALL take no grant in the first edge after rst deasserts unless a request is high at that edge.

Structure
REQ-027 SHALL place the FSM state enum (IDLE, SCAN), the requester index constants (CPU=0, DBG=1), and the NDIG and SW_W defaults in package gpio_pkg.
REQ-028 SHALL implement the two-requester round-robin in sub-module gpio_rr_arb, with inputs req[1:0] and en, and registered output gnt[1:0].

Verification
REQ-029 Reset, then cpu_req with cpu_wdata=0x8765_4321 -> cpu_gnt pulse on the next cycle, gpio_out=0x87654321, disp_digit 1,2,3,4,5,6,7,8 on disp_sel 0..7, then disp_valid=0.
REQ-030 cpu_req and dbg_req high together with data 0x0000_0011 and 0x0000_0022 -> the CPU is granted first (gpio_out=0x11); dbg_gnt comes 9 cycles later (gpio_out=0x22).
REQ-031 dbg_req raised at disp_sel=2 of a CPU scan -> no grant until IDLE; dbg_gnt follows the scan end, and the new scan shows dbg data.
REQ-032 sw_in=18'h2_6789, then 18'h3_FFFF -> gpio_in=0x0002_6789 after 2 cycles, then 0x0003_FFFF, with one sw_chg pulse per change and none while stable.
REQ-033 rst=0 asserted at disp_sel=3 -> all outputs 0 immediately; after release, no disp_valid until the next grant.
REQ-034 A repeated CPU write of identical data 0x0000_00FF -> a second grant and a full 8-cycle scan.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared types and constants for the GPIO write arbiter / hex-digit scanner.
package gpio_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    localparam int CPU = 0;
    localparam int DBG = 1;

    localparam int NDIG_DEFAULT = 8;
    localparam int SW_W_DEFAULT = 18;

endpackage

// File: rtl/gpio_rr_arb.sv
// Two-requester round-robin arbiter. A registered grant pulse is issued one edge
// after an enabled request; win is the combinational choice for that same edge.
module gpio_rr_arb
    import gpio_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic [1:0] win
);

    logic [1:0] gnt_q;
    logic       last_dbg_q;  // set when the debug port took the most recent grant

    always_comb begin
        win = 2'b00;
        if (en) begin
            case (req)
                2'b01:   win = 2'b01;
                2'b10:   win = 2'b10;
                2'b11:   win = last_dbg_q ? 2'b01 : 2'b10;
                default: win = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_q      <= 2'b00;
            last_dbg_q <= 1'b1;
        end else begin
            gnt_q <= win;
            if (|win) begin
                last_dbg_q <= win[DBG];
            end
        end
    end

    assign gnt = gnt_q;

endmodule

// File: rtl/gpio_arb_ctrl.sv
// GPIO block: switch synchronizer with change pulse, arbitrated CPU/debug writes
// to a display register, and an NDIG-cycle hex-digit scan after every write.
module gpio_arb_ctrl
    import gpio_pkg::*;
#(
    parameter int SW_W = SW_W_DEFAULT,
    parameter int NDIG = NDIG_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SW_W-1:0] sw_in,
    output logic [31:0]     gpio_in,
    output logic            sw_chg,
    input  logic            cpu_req,
    input  logic [31:0]     cpu_wdata,
    output logic            cpu_gnt,
    input  logic            dbg_req,
    input  logic [31:0]     dbg_wdata,
    output logic            dbg_gnt,
    output logic [31:0]     gpio_out,
    output logic            disp_valid,
    output logic [2:0]      disp_sel,
    output logic [3:0]      disp_digit
);

    logic [SW_W-1:0] sync1_q, sync2_q, sw_prev_q;
    state_e          state_q, state_d;
    logic [2:0]      sel_q, sel_d;
    logic [31:0]     out_q, out_d;
    logic [1:0]      req, gnt, win;
    logic [3:0]      nib [8];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            sw_prev_q <= '0;
        end else begin
            sync1_q   <= sw_in;
            sync2_q   <= sync1_q;
            sw_prev_q <= sync2_q;
        end
    end

    assign gpio_in = 32'(sync2_q);
    assign sw_chg  = (sync2_q != sw_prev_q);

    assign req = {dbg_req, cpu_req};

    gpio_rr_arb u_arb (
        .clk (clk),
        .rst (rst),
        .en  (state_q == IDLE),
        .req (req),
        .gnt (gnt),
        .win (win)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (|win) begin
                    state_d = SCAN;
                    sel_d   = 3'd0;
                    out_d   = win[DBG] ? dbg_wdata : cpu_wdata;
                end
            end
            SCAN: begin
                if (sel_q == 3'(NDIG - 1)) begin
                    state_d = IDLE;
                    sel_d   = 3'd0;
                end else begin
                    sel_d = sel_q + 3'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            out_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            out_q   <= out_d;
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_nib
        assign nib[gi] = out_q[4*gi +: 4];
    end

    assign cpu_gnt    = gnt[CPU];
    assign dbg_gnt    = gnt[DBG];
    assign gpio_out   = out_q;
    assign disp_valid = (state_q == SCAN);
    assign disp_sel   = sel_q;
    assign disp_digit = disp_valid ? nib[sel_q] : 4'h0;

endmodule

// File: tb/tb_gpio_arb_ctrl.sv
// Self-checking bench for gpio_arb_ctrl: directed scenarios plus a randomized
// request stream checked against a grant/scan reference model.
module tb_gpio_arb_ctrl;

    localparam int NDIG = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [17:0] sw_in = '0;
    logic [31:0] gpio_in;
    logic        sw_chg;
    logic        cpu_req = 1'b0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_gnt;
    logic        dbg_req = 1'b0;
    logic [31:0] dbg_wdata = '0;
    logic        dbg_gnt;
    logic [31:0] gpio_out;
    logic        disp_valid;
    logic [2:0]  disp_sel;
    logic [3:0]  disp_digit;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gpio_arb_ctrl #(.SW_W(18), .NDIG(NDIG)) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_in      (sw_in),
        .gpio_in    (gpio_in),
        .sw_chg     (sw_chg),
        .cpu_req    (cpu_req),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .dbg_req    (dbg_req),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .gpio_out   (gpio_out),
        .disp_valid (disp_valid),
        .disp_sel   (disp_sel),
        .disp_digit (disp_digit)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [74:0] snap;
        sw_in = 18'h1234;
        repeat (3) tick();
        snap = {gpio_out, gpio_in, sw_chg, cpu_gnt, dbg_gnt, disp_valid, disp_sel, disp_digit};
        total++;
        if (snap !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", snap);
        end
        sw_in = '0;
        rst = 1'b1;
        tick();
        total++;
        if ({cpu_gnt, dbg_gnt, disp_valid} !== 3'b000) begin
            bad++;
            $display("FAIL first_edge_no_grant got=%b want=000", {cpu_gnt, dbg_gnt, disp_valid});
        end
    endtask

    task automatic test_single_write();
        cpu_wdata = 32'h8765_4321;
        cpu_req = 1'b1;
        tick();
        cpu_req = 1'b0;
        total++;
        if ({cpu_gnt, dbg_gnt} !== 2'b10 || gpio_out !== 32'h8765_4321) begin
            bad++;
            $display("FAIL single_grant gnt=%b out=%h want gnt=10 out=87654321", {cpu_gnt, dbg_gnt}, gpio_out);
        end
        for (int k = 0; k < NDIG; k++) begin
            total++;
            if (disp_valid !== 1'b1 || disp_sel !== 3'(k) || disp_digit !== 4'(k + 1)
                || (k > 0 && (cpu_gnt | dbg_gnt) !== 1'b0)) begin
                bad++;
                $display("FAIL single_scan k=%0d valid=%b sel=%0d digit=%h gnt=%b want sel=%0d digit=%0d",
                         k, disp_valid, disp_sel, disp_digit, {cpu_gnt, dbg_gnt}, k, k + 1);
            end
            tick();
        end
        total++;
        if (disp_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_scan_end valid=%b want 0", disp_valid);
        end
    endtask

    task automatic test_round_robin();
        int n;
        do_reset();
        cpu_wdata = 32'h11;
        dbg_wdata = 32'h22;
        cpu_req = 1'b1;
        dbg_req = 1'b1;
        tick();
        total++;
        if ({cpu_gnt, dbg_gnt} !== 2'b10 || gpio_out !== 32'h11) begin
            bad++;
            $display("FAIL rr_first gnt=%b out=%h want gnt=10 out=11", {cpu_gnt, dbg_gnt}, gpio_out);
        end
        cpu_req = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (cpu_gnt || dbg_gnt) break;
        end
        dbg_req = 1'b0;
        total++;
        if (n !== 9 || {cpu_gnt, dbg_gnt} !== 2'b01 || gpio_out !== 32'h22) begin
            bad++;
            $display("FAIL rr_second delay=%0d gnt=%b out=%h want delay=9 gnt=01 out=22",
                     n, {cpu_gnt, dbg_gnt}, gpio_out);
        end
        repeat (NDIG) tick();
        total++;
        if (disp_valid !== 1'b0) begin
            bad++;
            $display("FAIL rr_scan_end valid=%b want 0", disp_valid);
        end
    endtask

    task automatic test_req_during_scan();
        int n;
        logic [31:0] cdat, ddat;
        cdat = $urandom;
        ddat = $urandom;
        cpu_wdata = cdat;
        cpu_req = 1'b1;
        tick();
        cpu_req = 1'b0;
        tick();
        tick();
        total++;
        if (disp_sel !== 3'd2) begin
            bad++;
            $display("FAIL mid_scan_sel got=%0d want=2", disp_sel);
        end
        dbg_wdata = ddat;
        dbg_req = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (cpu_gnt || dbg_gnt) break;
            total++;
            if (gpio_out !== cdat) begin
                bad++;
                $display("FAIL mid_scan_hold out=%h want=%h", gpio_out, cdat);
            end
        end
        dbg_req = 1'b0;
        total++;
        if (n !== 7 || {cpu_gnt, dbg_gnt} !== 2'b01 || gpio_out !== ddat) begin
            bad++;
            $display("FAIL mid_scan_grant wait=%0d gnt=%b out=%h want wait=7 gnt=01 out=%h",
                     n, {cpu_gnt, dbg_gnt}, gpio_out, ddat);
        end
        for (int k = 0; k < NDIG; k++) begin
            total++;
            if (disp_valid !== 1'b1 || disp_sel !== 3'(k) || disp_digit !== 4'((ddat >> (4 * k)) & 32'hF)) begin
                bad++;
                $display("FAIL dbg_scan k=%0d valid=%b sel=%0d digit=%h want digit=%h",
                         k, disp_valid, disp_sel, disp_digit, 4'((ddat >> (4 * k)) & 32'hF));
            end
            tick();
        end
    endtask

    task automatic test_same_data();
        int v;
        cpu_wdata = 32'h0000_00FF;
        cpu_req = 1'b1;
        tick();
        cpu_req = 1'b0;
        total++;
        if (cpu_gnt !== 1'b1 || gpio_out !== 32'hFF) begin
            bad++;
            $display("FAIL same_first gnt=%b out=%h want gnt=1 out=ff", cpu_gnt, gpio_out);
        end
        repeat (NDIG) tick();
        cpu_req = 1'b1;
        tick();
        cpu_req = 1'b0;
        total++;
        if (cpu_gnt !== 1'b1 || gpio_out !== 32'hFF) begin
            bad++;
            $display("FAIL same_second gnt=%b out=%h want gnt=1 out=ff", cpu_gnt, gpio_out);
        end
        v = 0;
        for (int i = 0; i < 12; i++) begin
            v += int'(disp_valid);
            tick();
        end
        total++;
        if (v !== NDIG) begin
            bad++;
            $display("FAIL same_scan_len got=%0d want=%0d", v, NDIG);
        end
    endtask

    task automatic test_switches();
        logic [17:0] vals [7];
        logic [17:0] old, v;
        int pulses;
        vals[0] = 18'h2_6789;
        vals[1] = 18'h3_FFFF;
        vals[2] = 18'h3_FFFF;
        for (int i = 3; i < 7; i++) vals[i] = 18'($urandom);
        old = sw_in;
        for (int i = 0; i < 7; i++) begin
            v = vals[i];
            sw_in = v;
            tick();
            total++;
            if (gpio_in !== 32'(old) || sw_chg !== 1'b0) begin
                bad++;
                $display("FAIL sw_stage1 in=%h chg=%b want in=%h chg=0", gpio_in, sw_chg, 32'(old));
            end
            tick();
            total++;
            if (gpio_in !== 32'(v) || sw_chg !== (v != old)) begin
                bad++;
                $display("FAIL sw_stage2 in=%h chg=%b want in=%h chg=%b", gpio_in, sw_chg, 32'(v), v != old);
            end
            pulses = 0;
            repeat (3) begin
                tick();
                pulses += int'(sw_chg);
            end
            total++;
            if (pulses !== 0) begin
                bad++;
                $display("FAIL sw_stable pulses=%0d want=0", pulses);
            end
            old = v;
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [74:0] snap;
        cpu_wdata = $urandom | 32'h1111_1111;
        cpu_req = 1'b1;
        tick();
        cpu_req = 1'b0;
        repeat (3) tick();
        total++;
        if (disp_sel !== 3'd3 || disp_valid !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_pre sel=%0d valid=%b want sel=3 valid=1", disp_sel, disp_valid);
        end
        #2;
        rst = 1'b0;
        #1;
        snap = {gpio_out, gpio_in, sw_chg, cpu_gnt, dbg_gnt, disp_valid, disp_sel, disp_digit};
        total++;
        if (snap !== '0) begin
            bad++;
            $display("FAIL rst_mid_outputs got=%h want=0", snap);
        end
        tick();
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            total++;
            if ({cpu_gnt, dbg_gnt, disp_valid} !== 3'b000 || gpio_out !== 32'd0) begin
                bad++;
                $display("FAIL rst_mid_after i=%0d gnt=%b valid=%b out=%h want all 0",
                         i, {cpu_gnt, dbg_gnt}, disp_valid, gpio_out);
            end
        end
    endtask

    task automatic test_random();
        bit          m_scan, last_dbg, g_cpu, g_dbg;
        int          idx;
        logic [31:0] m_out;
        logic [3:0]  m_dig;
        do_reset();
        m_scan = 1'b0;
        last_dbg = 1'b1;
        idx = 0;
        m_out = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!cpu_req && $urandom_range(3) == 0) begin
                cpu_req = 1'b1;
                cpu_wdata = $urandom;
            end
            if (!dbg_req && $urandom_range(3) == 0) begin
                dbg_req = 1'b1;
                dbg_wdata = $urandom;
            end
            @(posedge clk);
            g_cpu = 1'b0;
            g_dbg = 1'b0;
            if (m_scan) begin
                if (idx == NDIG - 1) m_scan = 1'b0;
                else idx++;
            end else if (cpu_req || dbg_req) begin
                g_dbg = (cpu_req && dbg_req) ? !last_dbg : dbg_req;
                g_cpu = !g_dbg;
                m_out = g_dbg ? dbg_wdata : cpu_wdata;
                last_dbg = g_dbg;
                m_scan = 1'b1;
                idx = 0;
            end
            #1;
            m_dig = 4'((m_out >> (4 * idx)) & 32'hF);
            total++;
            if ({cpu_gnt, dbg_gnt} !== {g_cpu, g_dbg} || gpio_out !== m_out || disp_valid !== m_scan
                || (m_scan && (disp_sel !== 3'(idx) || disp_digit !== m_dig))) begin
                bad++;
                $display("FAIL random cyc=%0d gnt=%b out=%h valid=%b sel=%0d digit=%h want gnt=%b out=%h valid=%b sel=%0d digit=%h",
                         cyc, {cpu_gnt, dbg_gnt}, gpio_out, disp_valid, disp_sel, disp_digit,
                         {g_cpu, g_dbg}, m_out, m_scan, idx, m_dig);
            end
            if (g_cpu) cpu_req = 1'b0;
            if (g_dbg) dbg_req = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_req_during_scan();
        test_same_data();
        test_switches();
        test_reset_mid_scan();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
